// File: rtl/spi_pkg.sv
// spi_pkg: FSM state encoding and default word width shared by the SPI shift engine.
package spi_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load, shift-left register with serial in and MSB serial out.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         sout
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[W-2:0], sin};
  assign sout = q[W-1];
endmodule

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI master data path; shifts a word out on o_mosi and in from i_miso,
// paced by externally generated leading/trailing clock edge pulses.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tx_valid,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_cpha,
  input  logic                  i_leading_edge,
  input  logic                  i_trailing_edge,
  input  logic                  i_miso,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_busy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic cpha_q, shifting, sample, tx_shift, tx_load;
  logic [DATA_WIDTH:0] tx_din, tx_q_unused;
  logic [DATA_WIDTH-1:0] rx_q;
  logic rx_msb_unused;
  // tx is one bit wider: CPHA=1 preloads a 0 so the first leading edge exposes the MSB
  assign shifting = state == SHIFT && cnt != LAST;
  assign sample   = shifting && (cpha_q ? i_trailing_edge : i_leading_edge);
  assign tx_shift = shifting && (cpha_q ? i_leading_edge : i_trailing_edge);
  assign tx_load  = state == LOAD || state == DONE;
  assign tx_din   = state == LOAD ? (i_cpha ? {1'b0, i_tx_data} : {i_tx_data, 1'b0}) : '0;
  spi_shift_reg #(.W(DATA_WIDTH + 1)) u_tx (
    .clk(clk), .rst(rst), .load(tx_load), .din(tx_din), .shift(tx_shift), .sin(1'b0),
    .q(tx_q_unused), .sout(o_mosi)
  );
  spi_shift_reg #(.W(DATA_WIDTH)) u_rx (
    .clk(clk), .rst(rst), .load(state == LOAD), .din('0), .shift(sample), .sin(i_miso),
    .q(rx_q), .sout(rx_msb_unused)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cpha_q     <= 1'b0;
      o_cs_n     <= 1'b1;
      o_busy     <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        IDLE:
          if (i_tx_valid) begin
            state  <= LOAD;
            o_cs_n <= 1'b0;
            o_busy <= 1'b1;
          end
        LOAD: begin
          state  <= SHIFT;
          cpha_q <= i_cpha;
          cnt    <= '0;
        end
        SHIFT:
          if (cnt == LAST) begin
            state      <= DONE;
            o_cs_n     <= 1'b1;
            o_rx_valid <= 1'b1;
            o_rx_data  <= rx_q;
          end else if (sample) cnt <= cnt + 1'b1;
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: randomized scoreboard bench with an edge generator and word-level reference.
module tb_spi_shift_engine;
  localparam int W = 8;
  logic clk = 0, rst = 0, i_tx_valid = 0, i_cpha = 0;
  logic i_leading_edge = 0, i_trailing_edge = 0, i_miso = 0;
  logic [W-1:0] i_tx_data = '0;
  logic o_mosi, o_cs_n, o_busy, o_rx_valid;
  logic [W-1:0] o_rx_data;
  int errors = 0, checks = 0, cyc = 0, last_samp = 0, k = 0, ph = -1;
  int per = 8, lp = 2, tp = 6;
  bit loopback = 1, manual = 0, prev_v = 0, cur_cp = 0;
  logic m_le = 0, m_te = 0, m_miso = 0;
  logic [W-1:0] rbits = '0, cur = '0, last_rx = '0;
  logic [W-1:0] rxq[$], dq[$];

  spi_shift_engine #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_tx_valid(i_tx_valid), .i_tx_data(i_tx_data), .i_cpha(i_cpha),
    .i_leading_edge(i_leading_edge), .i_trailing_edge(i_trailing_edge), .i_miso(i_miso),
    .o_mosi(o_mosi), .o_cs_n(o_cs_n), .o_busy(o_busy), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Edge generator: phase counts from the LOAD cycle; also tracks which bit the DUT should be sampling.
  initial forever begin
    @(negedge clk);
    if (manual) begin
      i_leading_edge = m_le;
      i_trailing_edge = m_te;
      i_miso = m_miso;
    end else begin
      ph = o_busy ? ph + 1 : -1;
      if (!o_busy) k = 0;
      if (ph == 0) begin
        cur_cp = i_cpha;
        if (dq.size() > 0) cur = dq.pop_front();
      end
      i_leading_edge = ph > 0 && ph % per == lp;
      i_trailing_edge = ph > 0 && ph % per == tp;
      i_miso = loopback ? o_mosi : (k < W ? rbits[W-1-k] : 1'b0);
      if ((cur_cp ? i_trailing_edge : i_leading_edge) && k < W) begin
        chk("mosi_bit", o_mosi, cur[W-1-k]);
        k++;
        if (k == W) last_samp = cyc;
      end
    end
  end

  // Monitor: every o_rx_valid pops one expected word.
  initial forever begin
    @(negedge clk);
    if (o_rx_valid) begin
      chk("rx_valid_width", prev_v, 0);
      if (rxq.size() == 0) chk("unexpected_rx_valid", o_rx_valid, 0);
      else begin
        last_rx = rxq.pop_front();
        chk("rx_data", o_rx_data, last_rx);
        chk("rx_latency", cyc - last_samp, 2);
      end
    end
    prev_v = o_rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic wait_busy(input logic lvl, input string nm);
    int n = 0;
    while (o_busy !== lvl && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, o_busy, lvl);
  endtask

  task automatic cfg(input int p, input int l, input int t, input bit lb, input logic [W-1:0] rb);
    per = p; lp = l; tp = t; loopback = lb; rbits = rb;
  endtask

  task automatic launch(input logic [W-1:0] d, input logic c);
    i_tx_data = d;
    i_cpha = c;
    i_tx_valid = 1;
    rxq.push_back(loopback ? d : rbits);
    dq.push_back(d);
    wait_busy(1, "start");
    i_tx_valid = 0;
  endtask

  task automatic run(input logic [W-1:0] d, input logic c);
    launch(d, c);
    wait_busy(0, "done");
    chk("idle_mosi", o_mosi, 0);
    chk("idle_cs_n", o_cs_n, 1);
  endtask

  task automatic wait_k(input int target);
    int n = 0;
    while (k < target && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reach_sample", k >= target, 1);
  endtask

  initial begin
    int n, p, l, t;
    logic c;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_cs_n", o_cs_n, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_mosi", o_mosi, 0);
    chk("rst_rx_valid", o_rx_valid, 0);
    chk("rst_rx_data", o_rx_data, 0);
    cfg(8, 2, 6, 1, '0);
    run(8'hA5, 0);
    cfg(8, 2, 6, 0, 8'hFF);
    run(8'h3C, 1);
    cfg(8, 2, 6, 1, '0);
    launch(8'h5A, 0);
    wait_k(3);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("abort_cs_n", o_cs_n, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_mosi", o_mosi, 0);
    chk("abort_rx_data", o_rx_data, 0);
    rxq.delete();
    dq.delete();
    last_rx = '0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_cs_n", o_cs_n, 1);
    run(8'h81, 0);
    launch(8'h12, 0);
    wait_k(2);
    @(negedge clk);
    i_tx_data = 8'hFF;
    i_tx_valid = 1;
    @(negedge clk);
    i_tx_valid = 0;
    wait_busy(0, "ignore_done");
    repeat (3) @(negedge clk);
    chk("ignore_no_requeue", o_busy, 0);
    manual = 1;
    repeat (12) begin
      @(negedge clk);
      m_le = 1'($urandom);
      m_te = 1'($urandom);
      m_miso = 1'($urandom);
      chk("idle_edges_cs_n", o_cs_n, 1);
      chk("idle_edges_busy", o_busy, 0);
      chk("idle_edges_rx_data", o_rx_data, last_rx);
    end
    m_le = 0; m_te = 0; m_miso = 0;
    repeat (2) @(negedge clk);
    manual = 0;
    cfg(4, 1, 1, 1, '0);
    run(8'hC3, 0);
    cfg(6, 2, 4, 1, '0);
    i_tx_data = 8'h69;
    i_cpha = 0;
    i_tx_valid = 1;
    rxq.push_back(8'h69);
    dq.push_back(8'h69);
    wait_busy(1, "b2b_start");
    @(negedge clk);
    i_tx_data = 8'h96;
    rxq.push_back(8'h96);
    dq.push_back(8'h96);
    n = 0;
    while (!o_cs_n && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_cs_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_cs_gap", n, 2);
    i_tx_valid = 0;
    wait_busy(0, "b2b_done");
    repeat (4) @(negedge clk);
    chk("b2b_no_third", o_busy, 0);
    for (int i = 0; i < 14; i++) begin
      c = 1'($urandom);
      p = $urandom_range(3, 8);
      l = $urandom_range(1, p - 2);
      t = c ? $urandom_range(l + 1, p - 1) : $urandom_range(l, p - 1);
      cfg(p, l, t, 1'($urandom), W'($urandom));
      run(W'($urandom), c);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", rxq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per transfer.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_tx_valid  input  1  start request, sampled in IDLE only.
REQ-005 SHALL have port i_tx_data  input  DATA_WIDTH  word to transmit, MSB first.
REQ-006 SHALL have port i_cpha  input  1  clock phase, sampled at transfer start.
REQ-007 SHALL have port i_leading_edge  input  1  one-cycle pulse from the signal generator.
REQ-008 SHALL have port i_trailing_edge  input  1  one-cycle pulse from the signal generator.
REQ-009 SHALL have port i_miso  input  1  serial data in.
REQ-010 SHALL have port o_mosi  output  1  serial data out.
REQ-011 SHALL have port o_cs_n  output  1  active-low chip select.
REQ-012 SHALL have port o_busy  output  1  high from LOAD through DONE.
REQ-013 SHALL have port o_rx_data  output  DATA_WIDTH  last received word, held until the next completion.
REQ-014 SHALL have port o_rx_valid  output  1  one-cycle pulse when o_rx_data updates.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-016 IDLE->LOAD when i_tx_valid=1; otherwise remain; edge pulses ignored in IDLE.
REQ-017 LOAD (one cycle): latch i_tx_data into tx shift reg, latch i_cpha, clear bit counter and rx shift reg, drive o_cs_n=0, o_busy=1; LOAD->SHIFT unconditionally.
REQ-018 CPHA=0: o_mosi = tx reg MSB from LOAD; on i_leading_edge sample i_miso into rx LSB (shift left); on i_trailing_edge shift tx reg left by one.
REQ-019 CPHA=1: on i_leading_edge shift tx reg left (first leading edge presents MSB; o_mosi=0 before it); on i_trailing_edge sample i_miso.
REQ-020 Bit counter SHALL increment on each sample edge; width clog2(DATA_WIDTH)+1; SHIFT->DONE on the cycle after the DATA_WIDTH-th sample.
REQ-021 DONE (one cycle): o_rx_data <= rx reg, o_rx_valid=1, o_cs_n=1; DONE->IDLE; o_busy deasserts in IDLE.
REQ-022 Total latency: o_rx_valid exactly 2 clk after the cycle of the DATA_WIDTH-th sample edge.
REQ-023 i_tx_valid while not IDLE SHALL be ignored, not queued.
REQ-024 Simultaneous i_leading_edge and i_trailing_edge SHALL perform sample before shift, same cycle.
REQ-025 Edge pulses outside SHIFT SHALL have no effect.
REQ-026 o_mosi SHALL return to 0 in IDLE.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, o_cs_n=1, o_busy=0, o_mosi=0, o_rx_valid=0, o_rx_data=0, counters and shift regs=0.
REQ-028 Reset mid-transfer SHALL abort without o_rx_valid; first clock after release is IDLE.

Structure
REQ-029 Shared package spi_pkg SHALL hold the FSM state encoding (2-bit) and DATA_WIDTH default.
REQ-030 The tx/rx shift logic SHALL be one sub-module spi_shift_reg (parallel load, shift-left enable, serial in/out), instantiated twice.
REQ-031 Target 120-400 lines RTL total.

Verification
REQ-032 CPHA=0, i_tx_data=0xA5, i_miso looped to o_mosi, edges every 8 clk (leading at phase 2, trailing at 6) -> o_mosi bits 1,0,1,0,0,1,0,1; o_rx_data=0xA5; one o_rx_valid pulse.
REQ-033 CPHA=1, i_tx_data=0x3C, i_miso=1 constant -> o_rx_data=0xFF; o_mosi 0,0,1,1,1,1,0,0 after each leading edge.
REQ-034 Reset asserted after 3rd sample of 0x5A -> all outputs at reset values immediately; no o_rx_valid; next transfer 0x81 completes correctly.
REQ-035 i_tx_valid pulsed during SHIFT with data 0xFF -> ignored; current 0x12 transfer completes unchanged; FSM returns to IDLE.
REQ-036 Edge pulses in IDLE with i_miso toggling -> o_cs_n=1, o_busy=0, o_rx_data unchanged, no o_rx_valid.
REQ-037 Back-to-back: i_tx_valid held high -> new LOAD on the cycle after IDLE re-entry; o_cs_n high for exactly 2 clk between transfers.
